ex_stage: RTL

- Execute stage; sits directly downstream of the decode stage, fed through the decode/execute pipeline register.
- Consumes the decoded operation, the two resolved operands and the destination register.
- Produces the writeback result for the execute/memory register, plus HI/LO write data.
- Logic, shift and arithmetic ops are single-cycle. DIV/DIVU use an iterative 32-step divider that stalls the pipeline.

---
 rtl/ex_stage_if.sv | 28 ++
 rtl/ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Decode/execute-side bundle for the execute stage: decoded operation in, writeback/HI-LO/stall out.
// master = upstream pipeline side, slave = ex_stage.
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arithmetic plus an optional iterative
// restoring divider (DIV/DIVU), built only when EX_DIV_EN is defined.
module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDI_OP = 8'b0101_0101;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  logic        is_div_op;
  logic [31:0] reg2_mux, sum;
  logic        ovf, lt_s, lt_u;
  logic [31:0] logic_res, shift_res, arith_res, alu_res;
  logic [31:0] hi_w, lo_w;
  logic        whilo_w, stall_w;

  assign is_div_op = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);

  always_comb begin
    reg2_mux = (bus.aluop_i == EXE_SUB_OP) ? (~bus.reg2_i + 32'd1) : bus.reg2_i;
    sum      = bus.reg1_i + reg2_mux;
    ovf      = 1'b0;
    if (bus.aluop_i == EXE_ADD_OP || bus.aluop_i == EXE_ADDI_OP || bus.aluop_i == EXE_SUB_OP)
      ovf = (bus.reg1_i[31] == reg2_mux[31]) && (sum[31] != bus.reg1_i[31]);
    lt_s = $signed(bus.reg1_i) < $signed(bus.reg2_i);
    lt_u = bus.reg1_i < bus.reg2_i;

    logic_res = '0;
    case (bus.aluop_i)
      EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
      EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
      EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
      EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
      default:    logic_res = '0;
    endcase

    shift_res = '0;
    case (bus.aluop_i)
      EXE_SLL_OP: shift_res = bus.reg2_i << bus.reg1_i[4:0];
      EXE_SRL_OP: shift_res = bus.reg2_i >> bus.reg1_i[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
      default:    shift_res = '0;
    endcase

    arith_res = '0;
    case (bus.aluop_i)
      EXE_SLT_OP:                        arith_res = {31'b0, lt_s};
      EXE_SLTU_OP:                       arith_res = {31'b0, lt_u};
      EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: arith_res = sum;
      default:                           arith_res = '0;
    endcase

    case (bus.alusel_i)
      EXE_RES_LOGIC:      alu_res = logic_res;
      EXE_RES_SHIFT:      alu_res = shift_res;
      EXE_RES_ARITHMETIC: alu_res = arith_res;
      default:            alu_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  localparam int CW = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic          negq_q, negq_d, negr_q, negr_d;
  logic [32:0]   rem_sh, diff;
  logic          ge, div_signed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DivFree;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder
  // each step while the new quotient bit enters at the LSB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    div_signed = (bus.aluop_i == EXE_DIV_OP);
    rem_sh     = {rem_q, quot_q[31]};
    diff       = rem_sh - {1'b0, dvsr_q};
    ge         = (rem_sh >= {1'b0, dvsr_q});

    case (state_q)
      DivFree: begin
        if (is_div_op && !bus.flush_i) begin
          dvsr_d  = (div_signed && bus.reg2_i[31]) ? -bus.reg2_i : bus.reg2_i;
          quot_d  = (div_signed && bus.reg1_i[31]) ? -bus.reg1_i : bus.reg1_i;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = div_signed && (bus.reg1_i[31] ^ bus.reg2_i[31]);
          negr_d  = div_signed && bus.reg1_i[31];
          state_d = (bus.reg2_i == 32'd0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        quot_d  = '0;
        rem_d   = '0;
        state_d = DivEnd;
      end
      DivOn: begin
        quot_d = {quot_q[30:0], ge};
        rem_d  = ge ? diff[31:0] : rem_sh[31:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(DIV_STEPS - 1))
          state_d = DivEnd;
      end
      DivEnd:  state_d = DivFree;
      default: state_d = DivFree;
    endcase

    if (bus.flush_i) begin
      state_d = DivFree;
      cnt_d   = '0;
      quot_d  = '0;
      rem_d   = '0;
      dvsr_d  = '0;
      negq_d  = 1'b0;
      negr_d  = 1'b0;
    end

    stall_w = is_div_op && (state_q != DivEnd) && !bus.flush_i;
    whilo_w = (state_q == DivEnd) && !bus.flush_i;
    lo_w    = whilo_w ? (negq_q ? -quot_q : quot_q) : '0;
    hi_w    = whilo_w ? (negr_q ? -rem_q  : rem_q)  : '0;
  end
`else
  logic unused_div;
  assign unused_div = ^{clk, bus.flush_i};
  assign stall_w    = 1'b0;
  assign whilo_w    = 1'b0;
  assign lo_w       = '0;
  assign hi_w       = '0;
`endif

  // Reset is asynchronous, so the combinational outputs are gated by rst as well.
  always_comb begin
    bus.wd_o       = '0;
    bus.wreg_o     = 1'b0;
    bus.wdata_o    = '0;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    bus.stallreq_o = 1'b0;
    if (!rst) begin
      bus.wd_o       = bus.wd_i;
      bus.wreg_o     = bus.wreg_i && !ovf && !is_div_op;
      bus.wdata_o    = is_div_op ? 32'd0 : alu_res;
      bus.whilo_o    = whilo_w;
      bus.hi_o       = hi_w;
      bus.lo_o       = lo_w;
      bus.stallreq_o = stall_w;
    end
  end
endmodule
